tt_um_uart_tx: RTL and testbench
================================

TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 87, clock cycles per serial bit (87 = 115200 baud at 10 MHz); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  always high while powered; ignored.
REQ-005 ui_in  input  8  byte to transmit; sampled only on acceptance.
REQ-006 uio_in  input  8  bit 0 = tx_valid; bits 7:1 ignored.
REQ-007 uo_out  output  8  bit 0 = txd (serial line, idle high); bit 1 = busy; bit 2 = done; bits 7:3 = 0.
REQ-008 uio_out  output  8  bit 1 = tx_ready; all other bits 0.
REQ-009 uio_oe  output  8  constant 8'h02 (only bit 1 driven).

Function
REQ-010 The block SHALL implement a state machine with states IDLE, START, DATA, STOP, plus PARITY when enabled (REQ-024).
REQ-011 tx_ready SHALL be 1 only in IDLE.
REQ-012 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; ui_in is latched into a shift register; next state is START.
REQ-013 tx_valid in any state other than IDLE SHALL be ignored; ui_in changes mid-frame SHALL NOT affect the frame.
REQ-014 All outputs SHALL be registered; txd SHALL go low in the first cycle after the acceptance edge.
REQ-015 Each bit (start, data, parity, stop) SHALL hold txd for exactly CLKS_PER_BIT cycles.
REQ-016 Frame order SHALL be: start=0, data bits LSB first, optional parity, stop=1.
REQ-017 busy SHALL be 1 from the cycle after acceptance through the last stop-bit cycle.
REQ-018 done SHALL pulse high for exactly 1 cycle, coincident with the first IDLE cycle after the stop bit.
REQ-019 Latency from acceptance edge to tx_ready=1 SHALL be 10*CLKS_PER_BIT cycles without parity, 11*CLKS_PER_BIT with parity.
REQ-020 With tx_valid held high, the next frame SHALL be accepted on the first IDLE edge, so its start bit directly follows the previous stop bit with no extra idle cycles.
REQ-021 Bit counter: 3 bits, wraps 7 -> exit DATA. Baud counter: $clog2(CLKS_PER_BIT) bits, reloads to 0 at CLKS_PER_BIT-1.

Reset
REQ-022 While rst_n=0, outputs SHALL asynchronously take these values: txd=1, busy=0, done=0, tx_ready=1; state=IDLE; counters=0; shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with no stop bit or done pulse; the first edge after release may accept a new byte.

Configuration
REQ-024 With macro UART_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame.
REQ-025 Without UART_TX_PARITY_EN, no PARITY state or logic SHALL exist and the frame SHALL be 10 bits.

Structure
REQ-026 Package tt_uart_pkg SHALL hold the state enum type, DATA_BITS=8, and the frame-length constants for both configurations.
REQ-027 Sub-module uart_bit_timer SHALL generate the per-bit end-of-bit tick from CLKS_PER_BIT; it is cleared on acceptance.
REQ-028 uart_bit_timer and the FSM/shift register in tt_um_uart_tx SHALL together fit within 120-400 lines of RTL.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset: rst_n=0 -> txd=1, tx_ready=1, busy=0, done=0, uio_oe=8'h02, uo_out[7:3]=0.
REQ-030 Single byte: ui_in=8'hA5, 1-cycle tx_valid -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done pulse at cycle 40; tx_ready=1 at cycle 40.
REQ-031 Back-to-back: tx_valid held high, 8'h00 then 8'hFF -> 80 contiguous cycles of frame bits, no idle gap, two done pulses 40 cycles apart.
REQ-032 Busy ignore: tx_valid=1 with ui_in=8'h3C during an 8'hA5 frame -> only the 8'hA5 frame is transmitted, tx_ready stays 0.
REQ-033 Mid-frame reset: rst_n=0 during data bit 3 -> txd=1 immediately, no done pulse; a byte sent after release transmits correctly.
REQ-034 UART_TX_PARITY_EN defined: ui_in=8'h07 -> parity bit 1 after data, frame 44 cycles, done at cycle 44.

Source files
------------

// File: rtl/tt_uart_pkg.sv
// tt_uart_pkg: shared types, constants and helpers for the tt_um_uart_tx UART
// transmitter. Optional even-parity support is selected by defining the
// UART_TX_PARITY_EN macro, which adds a PARITY state and an 11-bit frame.
package tt_uart_pkg;

  // Payload width of one character.
  localparam int DATA_BITS = 8;

  // Serial frame lengths in bit periods: start + data + stop, and the same
  // with one extra even-parity bit.
  localparam int FRAME_BITS_NO_PARITY = 1 + DATA_BITS + 1;
  localparam int FRAME_BITS_PARITY    = 1 + DATA_BITS + 1 + 1;

  // Index of the final data bit, used by the 3-bit bit counter to leave DATA.
  localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_e;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } txState_e;
`endif

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic evenParity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter for tt_um_uart_tx. Counts 0..CLKS_PER_BIT-1 and
// flags the last cycle of each bit period (tick_o). tickEarly_o flags the
// cycle before that, letting the stop bit hand its final cycle over to IDLE so
// that back-to-back frames stay contiguous. Parity support in the parent is
// controlled by UART_TX_PARITY_EN; this timer is identical in both builds.
module uart_bit_timer
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o,
  output logic tickEarly_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and reload to 0 after the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Baud counter register, zeroed asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = en_i && (cnt_q == CNT_LAST);
  assign tickEarly_o = en_i && (cnt_q == CNT_EARLY);

endmodule

// File: rtl/tt_um_uart_tx.sv
// tt_um_uart_tx: 8N1 UART transmitter in the Tiny Tapeout wrapper pinout.
// ui_in carries the byte, uio_in[0] is tx_valid, uo_out[2:0] = {done, busy, txd},
// uio_out[1] = tx_ready. All outputs come straight from flops.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// Timing: the stop bit spends CLKS_PER_BIT-1 cycles in STOP and its final
// cycle in IDLE, where tx_ready and done are high. A held tx_valid is then
// accepted on that IDLE edge so the next start bit follows the stop bit with
// no gap, and frames repeat every FRAME_BITS*CLKS_PER_BIT cycles.
module tt_um_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  txState_e state_q;
  txState_e state_d;

  logic [DATA_BITS-1:0] shiftReg_q;
  logic [DATA_BITS-1:0] shiftReg_d;
  logic [2:0]           bitCnt_q;
  logic [2:0]           bitCnt_d;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
  logic parity_d;
`endif

  logic txd_q;
  logic txd_d;
  logic busy_q;
  logic busy_d;
  logic done_q;
  logic done_d;
  logic ready_q;
  logic ready_d;

  logic txValid;
  logic bitTick;
  logic bitTickEarly;
  logic stopFinish;
  logic timerClr;
  logic timerEn;

  // ena is always high and uio_in[7:1] carry nothing for this block.
  logic unusedInputs;
  assign unusedInputs = &{1'b0, ena, uio_in[7:1]};

  assign txValid = uio_in[0];

  // Hold the baud counter at zero in IDLE so every frame starts on a fresh bit period.
  assign timerClr = (state_q == ST_IDLE);
  assign timerEn  = (state_q != ST_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (timerClr),
    .en_i       (timerEn),
    .tick_o     (bitTick),
    .tickEarly_o(bitTickEarly)
  );

  // Next-state logic: accept in IDLE, walk start/data/(parity)/stop on bit ticks.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    stopFinish = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (txValid) begin
          state_d    = ST_START;
          shiftReg_d = ui_in;
          bitCnt_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d   = evenParity(ui_in);
`endif
        end
      end

      ST_START: begin
        if (bitTick) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bitTick) begin
          shiftReg_d = shiftReg_q >> 1;
          bitCnt_d   = bitCnt_q + 3'd1;
          if (bitCnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bitTick) begin
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bitTickEarly) begin
          state_d    = ST_IDLE;
          stopFinish = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every pin is driven by a flop.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shiftReg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = stopFinish;
    busy_d  = (state_d != ST_IDLE) || stopFinish;
  end

  // State, datapath and output registers; reset leaves the line idle and ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign uo_out  = {5'b00000, done_q, busy_q, txd_q};
  assign uio_out = {6'b000000, ready_q, 1'b0};
  assign uio_oe  = 8'h02;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// tb_tt_um_uart_tx: self-checking bench for tt_um_uart_tx with CLKS_PER_BIT=4.
// Expected line levels are pushed per cycle into a queue when a byte is
// offered and popped as the DUT shifts it out. Define UART_TX_PARITY_EN to
// exercise the 11-bit parity frame.
module tb_tt_um_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic txd;
  logic busy;
  logic done;
  logic ready;

  int nChecks;
  int nFails;

  logic txdQ[$];

  assign txd   = uo_out[0];
  assign busy  = uo_out[1];
  assign done  = uo_out[2];
  assign ready = uio_out[1];

  tt_um_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: expected txd for every cycle of one frame.
  task automatic pushFrame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < CPB; c++) txdQ.push_back(bits[i]);
    end
  endtask

  function automatic logic popExpected();
    if (txdQ.size() == 0) return 1'b1;
    return txdQ.pop_front();
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    nChecks++; if (txd !== 1'b1) begin nFails++; $display("[TB] FAIL reset_txd: got %b expected 1", txd); end
    nChecks++; if (ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nChecks++; if (uio_oe !== 8'h02) begin nFails++; $display("[TB] FAIL reset_uio_oe: got %h expected 02", uio_oe); end
    nChecks++; if (uo_out[7:3] !== 5'b0) begin nFails++; $display("[TB] FAIL reset_uo_hi: got %b expected 00000", uo_out[7:3]); end
    nChecks++; if ((uio_out & 8'hFD) !== 8'h00) begin nFails++; $display("[TB] FAIL reset_uio_out: got %h expected 00 outside bit 1", uio_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    nChecks++; if (txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL post_reset_idle: got txd=%b ready=%b busy=%b expected 1 1 0", txd, ready, busy);
    end
  endtask

  task automatic test_single_byte();
    logic expBit;
    @(negedge clk);
    ui_in  = 8'hA5;
    uio_in = 8'h01;
    pushFrame(8'hA5);
    for (int k = 1; k <= FRAME_CYCLES; k++) begin
      @(negedge clk);
      if (k == 1) begin uio_in = 8'h00; ui_in = 8'hFF; end
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL single_txd cycle %0d: got %b expected %b", k, txd, expBit); end
      nChecks++; if (done !== (k == FRAME_CYCLES)) begin nFails++; $display("[TB] FAIL single_done cycle %0d: got %b expected %b", k, done, (k == FRAME_CYCLES)); end
      nChecks++; if (ready !== (k == FRAME_CYCLES)) begin nFails++; $display("[TB] FAIL single_ready cycle %0d: got %b expected %b", k, ready, (k == FRAME_CYCLES)); end
      if (k < FRAME_CYCLES) begin
        nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL single_busy cycle %0d: got %b expected 1", k, busy); end
      end
    end
    @(negedge clk);
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL single_done_width: got %b expected 0", done); end
    nChecks++; if (busy !== 1'b0 || txd !== 1'b1 || ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL single_idle_after: got busy=%b txd=%b ready=%b expected 0 1 1", busy, txd, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic expBit;
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h01;
    pushFrame(8'h00);
    pushFrame(8'hFF);
    for (int k = 1; k <= 2 * FRAME_CYCLES; k++) begin
      @(negedge clk);
      if (k == FRAME_CYCLES) ui_in = 8'hFF;
      if (k == FRAME_CYCLES + 1) uio_in = 8'h00;
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL b2b_txd cycle %0d: got %b expected %b", k, txd, expBit); end
      nChecks++; if (done !== (k == FRAME_CYCLES || k == 2 * FRAME_CYCLES)) begin
        nFails++; $display("[TB] FAIL b2b_done cycle %0d: got %b expected %b", k, done, (k == FRAME_CYCLES || k == 2 * FRAME_CYCLES));
      end
      nChecks++; if (ready !== (k == FRAME_CYCLES || k == 2 * FRAME_CYCLES)) begin
        nFails++; $display("[TB] FAIL b2b_ready cycle %0d: got %b expected %b", k, ready, (k == FRAME_CYCLES || k == 2 * FRAME_CYCLES));
      end
    end
    @(negedge clk);
    nChecks++; if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      nFails++; $display("[TB] FAIL b2b_idle_after: got txd=%b busy=%b done=%b expected 1 0 0", txd, busy, done);
    end
  endtask

  task automatic test_busy_ignore();
    logic expBit;
    @(negedge clk);
    ui_in  = 8'hA5;
    uio_in = 8'h01;
    pushFrame(8'hA5);
    for (int k = 1; k <= FRAME_CYCLES; k++) begin
      @(negedge clk);
      if (k == 1) uio_in = 8'h00;
      if (k == 8) begin ui_in = 8'h3C; uio_in = 8'h01; end
      if (k == 30) uio_in = 8'h00;
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL ignore_txd cycle %0d: got %b expected %b", k, txd, expBit); end
      if (k < FRAME_CYCLES) begin
        nChecks++; if (ready !== 1'b0) begin nFails++; $display("[TB] FAIL ignore_ready cycle %0d: got %b expected 0", k, ready); end
      end
    end
    for (int k = 1; k <= 2 * CPB; k++) begin
      @(negedge clk);
      nChecks++; if (txd !== 1'b1 || busy !== 1'b0) begin
        nFails++; $display("[TB] FAIL ignore_no_second_frame idle cycle %0d: got txd=%b busy=%b expected 1 0", k, txd, busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic expBit;
    @(negedge clk);
    ui_in  = 8'hA5;
    uio_in = 8'h01;
    pushFrame(8'hA5);
    // Data bit 3 occupies cycles 4*CPB+1 .. 5*CPB; abort in its second cycle.
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      if (k == 1) uio_in = 8'h00;
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL midrst_pre_txd cycle %0d: got %b expected %b", k, txd, expBit); end
    end
    rst_n = 1'b0;
    #1;
    nChecks++; if (txd !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_txd: got %b expected 1", txd); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    nChecks++; if (ready !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_ready: got %b expected 1", ready); end
    txdQ.delete();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      nChecks++; if (done !== 1'b0 || txd !== 1'b1) begin
        nFails++; $display("[TB] FAIL midrst_hold cycle %0d: got done=%b txd=%b expected 0 1", k, done, txd);
      end
    end
    ui_in  = 8'h5A;
    uio_in = 8'h01;
    rst_n  = 1'b1;
    pushFrame(8'h5A);
    for (int k = 1; k <= FRAME_CYCLES; k++) begin
      @(negedge clk);
      if (k == 1) uio_in = 8'h00;
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL midrst_post_txd cycle %0d: got %b expected %b", k, txd, expBit); end
      nChecks++; if (done !== (k == FRAME_CYCLES)) begin nFails++; $display("[TB] FAIL midrst_post_done cycle %0d: got %b expected %b", k, done, (k == FRAME_CYCLES)); end
    end
    @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic expBit;
    @(negedge clk);
    ui_in  = 8'h07;
    uio_in = 8'h01;
    pushFrame(8'h07);
    for (int k = 1; k <= FRAME_CYCLES; k++) begin
      @(negedge clk);
      if (k == 1) uio_in = 8'h00;
      expBit = popExpected();
      nChecks++; if (txd !== expBit) begin nFails++; $display("[TB] FAIL parity_txd cycle %0d: got %b expected %b", k, txd, expBit); end
      if (k > 9 * CPB && k <= 10 * CPB) begin
        nChecks++; if (txd !== 1'b1) begin nFails++; $display("[TB] FAIL parity_bit cycle %0d: got %b expected 1", k, txd); end
      end
      nChecks++; if (done !== (k == 44)) begin nFails++; $display("[TB] FAIL parity_done cycle %0d: got %b expected %b", k, done, (k == 44)); end
    end
    @(negedge clk);
  endtask
`endif

  // Test sequence and summary.
  initial begin
    nChecks = 0;
    nFails  = 0;
    rst_n   = 1'b0;
    ena     = 1'b1;
    ui_in   = 8'h00;
    uio_in  = 8'h00;
    $display("[TB] starting tt_um_uart_tx bench, frame %0d cycles", FRAME_CYCLES);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_busy_ignore();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
